// File: rtl/yacht_pkg.sv
// Shared constants and types for the Yacht score calculator:
// category codes, score constants, datapath widths and FSM states.
package yacht_pkg;

  localparam int NUM_CAT = 12;
  localparam int SCORE_W = 6;
  localparam int SUM_W   = 5;
  localparam int CNT_W   = 3;

  localparam logic [3:0] CAT_ONES       = 4'd0;
  localparam logic [3:0] CAT_TWOS       = 4'd1;
  localparam logic [3:0] CAT_THREES     = 4'd2;
  localparam logic [3:0] CAT_FOURS      = 4'd3;
  localparam logic [3:0] CAT_FIVES      = 4'd4;
  localparam logic [3:0] CAT_SIXES      = 4'd5;
  localparam logic [3:0] CAT_CHOICE     = 4'd6;
  localparam logic [3:0] CAT_FOUR_KIND  = 4'd7;
  localparam logic [3:0] CAT_FULL_HOUSE = 4'd8;
  localparam logic [3:0] CAT_SMALL_STR  = 4'd9;
  localparam logic [3:0] CAT_LARGE_STR  = 4'd10;
  localparam logic [3:0] CAT_YACHT      = 4'd11;

  localparam logic [SCORE_W-1:0] SS_SCORE    = 6'd15;
  localparam logic [SCORE_W-1:0] LS_SCORE    = 6'd30;
  localparam logic [SCORE_W-1:0] YACHT_SCORE = 6'd50;

  // Per-face occurrence counters, indexed directly by face value 1..6.
  typedef logic [6:1][CNT_W-1:0] hist_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_EVAL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/yacht_score_calc_if.sv
// Start/valid handshake between the game FSM (master) and the score
// calculator (slave). With CATEGORY_MASK_EN defined the bundle also carries
// the used-category mask.
interface yacht_score_calc_if;
  import yacht_pkg::*;

  logic               calc_start;
  logic [3:0]         category;
  logic [2:0]         dice1;
  logic [2:0]         dice2;
  logic [2:0]         dice3;
  logic [2:0]         dice4;
  logic [2:0]         dice5;
`ifdef CATEGORY_MASK_EN
  logic [NUM_CAT-1:0] used_mask;
`endif
  logic               busy;
  logic               score_valid;
  logic [SCORE_W-1:0] score;
  logic               dice_err;
  logic               cat_err;

  modport master (
`ifdef CATEGORY_MASK_EN
    output used_mask,
`endif
    output calc_start, category, dice1, dice2, dice3, dice4, dice5,
    input  busy, score_valid, score, dice_err, cat_err
  );

  modport slave (
`ifdef CATEGORY_MASK_EN
    input  used_mask,
`endif
    input  calc_start, category, dice1, dice2, dice3, dice4, dice5,
    output busy, score_valid, score, dice_err, cat_err
  );

endinterface

// File: rtl/yacht_category_eval.sv
// Combinational scorer: maps a face histogram, dice sum and category code
// to the raw category score. Error masking is done by the caller.
module yacht_category_eval
  import yacht_pkg::*;
(
  input  hist_t              i_cnt,
  input  logic [SUM_W-1:0]   i_sum,
  input  logic [3:0]         i_category,
  output logic [SCORE_W-1:0] o_score
);

  logic [6:1]         w_present;
  logic               w_four;
  logic               w_five;
  logic               w_three;
  logic               w_two;
  logic [SCORE_W-1:0] w_upper;
  logic               w_small;
  logic               w_large;

  // Histogram shape flags and the upper-section score for the selected face.
  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_present = '0;
    w_four    = 1'b0;
    w_five    = 1'b0;
    w_three   = 1'b0;
    w_two     = 1'b0;
    w_upper   = '0;
    for (int f = 1; f <= 6; f++) begin
      w_present[f] = (i_cnt[f] != '0);
      if (i_cnt[f] >= 3'd4) w_four  = 1'b1;
      if (i_cnt[f] == 3'd5) w_five  = 1'b1;
      if (i_cnt[f] == 3'd3) w_three = 1'b1;
      if (i_cnt[f] == 3'd2) w_two   = 1'b1;
      if (i_category == 4'(f - 1))
        w_upper = SCORE_W'(i_cnt[f]) * SCORE_W'(f);
    end
    w_small = (&w_present[4:1]) | (&w_present[5:2]) | (&w_present[6:3]);
    w_large = (&w_present[5:1]) | (&w_present[6:2]);
  end

  // Category select; illegal codes fall through to zero.
  always_comb begin
    o_score = '0;
    case (i_category)
      CAT_ONES, CAT_TWOS, CAT_THREES,
      CAT_FOURS, CAT_FIVES, CAT_SIXES: o_score = w_upper;
      CAT_CHOICE:     o_score = SCORE_W'(i_sum);
      CAT_FOUR_KIND:  o_score = w_four ? SCORE_W'(i_sum) : '0;
      // Five of a kind has no count of exactly 3 or 2, so it scores 0 here.
      CAT_FULL_HOUSE: o_score = (w_three && w_two) ? SCORE_W'(i_sum) : '0;
      CAT_SMALL_STR:  o_score = w_small ? SS_SCORE : '0;
      CAT_LARGE_STR:  o_score = w_large ? LS_SCORE : '0;
      CAT_YACHT:      o_score = w_five ? YACHT_SCORE : '0;
      default:        o_score = '0;
    endcase
  end

endmodule

// File: rtl/yacht_score_calc.sv
// Yacht score calculator top. Snapshots the five dice and the category on
// an accepted start, histograms one die per cycle, scores in EVAL and
// presents a one-cycle score_valid in DONE. Optional macro
// CATEGORY_MASK_EN adds a used-category mask that flags reused categories.
module yacht_score_calc
  import yacht_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  yacht_score_calc_if.slave bus
);

  state_t             r_state;
  state_t             w_next;
  logic               w_busy;
  logic               w_valid;
  logic               w_accept;

  logic [4:0][2:0]    r_dice;
  logic [3:0]         r_cat;
`ifdef CATEGORY_MASK_EN
  logic [NUM_CAT-1:0] r_mask;
`endif

  hist_t              r_cnt;
  logic [SUM_W-1:0]   r_sum;
  logic [2:0]         r_idx;
  logic               r_dice_bad;
  logic [2:0]         w_face;
  logic               w_face_ok;
  logic               w_cat_err;
  logic [SCORE_W-1:0] w_eval_score;

  logic [SCORE_W-1:0] r_score;
  logic               r_dice_err;
  logic               r_cat_err;

  assign w_accept = (r_state == ST_IDLE) && bus.calc_start;

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_next  = r_state;
    w_busy  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      ST_IDLE:  if (bus.calc_start) w_next = ST_COUNT;
      ST_COUNT: begin
        w_busy = 1'b1;
        if (r_idx == 3'd4) w_next = ST_EVAL;
      end
      ST_EVAL:  begin
        w_busy = 1'b1;
        w_next = ST_DONE;
      end
      ST_DONE:  begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
        w_next  = ST_IDLE;
      end
      default:  w_next = ST_IDLE;
    endcase
  end

  // Input snapshot taken at acceptance; later dice changes are ignored.
  // NOTE: these capture registers carry no reset because nothing reads them
  // before an acceptance has loaded them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_dice <= {bus.dice5, bus.dice4, bus.dice3, bus.dice2, bus.dice1};
      r_cat  <= bus.category;
`ifdef CATEGORY_MASK_EN
      r_mask <= bus.used_mask;
`endif
    end
  end

  // Die currently being counted.
  always_comb begin
    w_face = '0;
    case (r_idx)
      3'd0:    w_face = r_dice[0];
      3'd1:    w_face = r_dice[1];
      3'd2:    w_face = r_dice[2];
      3'd3:    w_face = r_dice[3];
      3'd4:    w_face = r_dice[4];
      default: w_face = '0;
    endcase
  end

  assign w_face_ok = (w_face != 3'd0) && (w_face != 3'd7);

  // Category error: out-of-range code, or (with the mask) an already used one.
  always_comb begin
    w_cat_err = (r_cat >= 4'(NUM_CAT));
`ifdef CATEGORY_MASK_EN
    for (int c = 0; c < NUM_CAT; c++)
      if (r_cat == 4'(c) && r_mask[c]) w_cat_err = 1'b1;
`endif
  end

  yacht_category_eval u_eval (
    .i_cnt      (r_cnt),
    .i_sum      (r_sum),
    .i_category (r_cat),
    .o_score    (w_eval_score)
  );

  // Histogram/sum accumulation during COUNT and result registration in EVAL.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_sum      <= '0;
      r_idx      <= '0;
      r_dice_bad <= 1'b0;
      r_score    <= '0;
      r_dice_err <= 1'b0;
      r_cat_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.calc_start) begin
            r_cnt      <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_dice_bad <= 1'b0;
          end
        end
        ST_COUNT: begin
          r_idx <= r_idx + 3'd1;
          if (w_face_ok) begin
            r_sum <= r_sum + SUM_W'(w_face);
            for (int f = 1; f <= 6; f++)
              if (w_face == 3'(f)) r_cnt[f] <= r_cnt[f] + 3'd1;
          end else begin
            r_dice_bad <= 1'b1;
          end
        end
        ST_EVAL: begin
          r_score    <= (r_dice_bad || w_cat_err) ? '0 : w_eval_score;
          r_dice_err <= r_dice_bad;
          r_cat_err  <= w_cat_err;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = w_busy;
  assign bus.score_valid = w_valid;
  assign bus.score       = r_score;
  assign bus.dice_err    = r_dice_err;
  assign bus.cat_err     = r_cat_err;

endmodule

// File: doc/yacht_score_calc.md
Name: yacht_score_calc

Overview:
Reads the five dice values driven by the dice roller and computes the Yacht score for one requested category. The game FSM starts it through a start/valid handshake. It sits between the dice roller and the game FSM/score board. Dice are snapshotted at start, so a roll during evaluation cannot corrupt the result.

Parameters:
NUM_CAT, 12, number of legal categories (codes 0..NUM_CAT-1)
SCORE_W, 6, score output width (max score 50)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
calc_start  input  1  start request; sampled only in IDLE
category  input  4  category code, captured with calc_start
dice1..dice5  input  3 each  die faces; legal 1..6 (0 = never rolled)
busy  output  1  high from the cycle after acceptance through the score_valid cycle
score_valid  output  1  single-cycle pulse; score/flags valid
score  output  SCORE_W  category score
dice_err  output  1  any snapshotted die outside 1..6
cat_err  output  1  category code >= NUM_CAT

Behaviour:
- Reset is synchronous and active-high. On reset: state IDLE; busy=0, score_valid=0, score=0, dice_err=0, cat_err=0; histogram and sum cleared.
- Category codes: 0..5 = Ones..Sixes; 6 = Choice; 7 = FourKind; 8 = FullHouse; 9 = SmallStraight; 10 = LargeStraight; 11 = Yacht.
- FSM: IDLE -> COUNT -> EVAL -> DONE -> IDLE.
- IDLE: if calc_start=1 in cycle N, latch dice1..5 and category, clear histogram and sum, idx=0, go to COUNT.
- COUNT: cycles N+1..N+5. Each cycle processes one snapshotted die (idx 0..4): cnt[face] += 1 (3-bit counters), sum += face (5-bit). An illegal face (0 or 7) sets a sticky dice_bad and adds nothing.
- EVAL: cycle N+6. Score is computed from the histogram and sum and registered.
- DONE: cycle N+7. score_valid=1 for exactly one cycle; next state IDLE.
- Handshake: busy=1 in cycles N+1..N+7. calc_start is ignored while busy (no queueing). A new start is first accepted in cycle N+8.
- score, dice_err and cat_err hold their values until the next DONE.
- Scoring:
  - Upper k (face f=k+1): cnt[f]*f.
  - Choice: sum.
  - FourKind: sum if any cnt>=4, else 0.
  - FullHouse: sum if counts are exactly {3,2}, else 0 (five-of-a-kind scores 0).
  - SmallStraight: 15 if faces {1-4}, {2-5} or {3-6} are all present.
  - LargeStraight: 30 if {1-5} or {2-6}.
  - Yacht: 50 if any cnt=5.
- Error precedence: dice_err or cat_err forces score=0. Both flags may be set together.
- Snapshotted dice make input changes after cycle N irrelevant.
- Reset asserted mid-operation: returns to IDLE next edge. No score_valid is produced; outputs take their reset values.
- Widths: no overflow possible (sum <= 30, upper <= 30, score <= 50 < 64).

Optional Feature:
CATEGORY_MASK_EN
- Defined: adds input used_mask [NUM_CAT-1:0], captured at acceptance. If the bit for the selected legal category is set, that evaluation gives score=0 and cat_err=1.
- Undefined: no port exists; the used-category check is the game FSM's job.

Decomposition:
- Package yacht_pkg: category code localparams (CAT_ONES..CAT_YACHT), NUM_CAT, score constants (SS_SCORE=15, LS_SCORE=30, YACHT_SCORE=50), FSM state encoding.
- Sub-module yacht_category_eval: purely combinational. Takes histogram, sum and category; returns score. Instantiated once in the EVAL path.

Test Plan:
- Dice {3,3,3,5,5}, category 8, start in cycle N: busy in N+1..N+7; score_valid only in N+7 with score=19, no errors.
- Dice {1,2,3,4,6}: category 9 gives 15, category 10 gives 0, category 0 gives 1, category 6 gives 16.
- Dice {6,6,6,6,6}: Yacht 50, FourKind 30, FullHouse 0, Sixes 30.
- Start straight after reset with dice all 0, category 6: dice_err=1, score=0. Category 13 with legal dice: cat_err=1, score=0.
- Hold calc_start=1 continuously and change dice in N+2: exactly one score_valid per 8 cycles, each computed from the dice at acceptance.
- Assert reset in N+3: no score_valid, busy=0 next cycle. A fresh start afterwards completes normally.
